// File: rtl/bit_mem_ctrl.sv
// Access controller for an 8x8 latch-based bitcell array.
// Two requesters (A=0, B=1) share the array through a round-robin arbiter.
// Every operation runs SETUP -> STROBE (STROBE_CYCLES) -> RELEASE, so rw and
// column data settle a cycle before the row select rises and remain a cycle
// after it falls. All array-facing signals come straight from flops.
//
// Handshake: a requester raises req_valid[i] with its fields and holds them
// until it sees req_valid[i] & req_ready[i] at a rising edge. That edge
// accepts the request. req_ready is combinational, is asserted only in IDLE,
// and goes to at most one requester. Dropping valid before acceptance is
// allowed and produces no operation. Completion is a one-cycle
// rsp_valid[owner] pulse. rsp_rdata is valid with that pulse for reads.
//
// STROBE_CYCLES must lie in 1..15 because it loads a 4-bit down-counter.
module bit_mem_ctrl #(
   parameter int ADDR_W        = 3,
   parameter int DATA_W        = 8,
   parameter int STROBE_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req_valid,
   input  logic [1:0]            req_we,
   input  logic [2*ADDR_W-1:0]   req_addr,
   input  logic [2*DATA_W-1:0]   req_wdata,
   output logic [1:0]            req_ready,
   output logic [1:0]            rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic [2**ADDR_W-1:0]  mem_sel,
   output logic                  mem_rw,
   output logic [DATA_W-1:0]     mem_data,
   input  logic [DATA_W-1:0]     mem_q,
   output logic                  busy
);

   localparam int         ROWS        = 2**ADDR_W;
   localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETUP   = 2'd1,
      ST_STROBE  = 2'd2,
      ST_RELEASE = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                owner_q, owner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                last_q, last_d;        // 1 = B was granted last
   logic [ROWS-1:0]     mem_sel_q, mem_sel_d;
   logic                mem_rw_q, mem_rw_d;
   logic [DATA_W-1:0]   mem_data_q, mem_data_d;
   logic [1:0]          rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

   logic                accept;
   logic                grant_b;

   // Round-robin arbiter: one ready at most, only while idle.
   always_comb begin
      req_ready = 2'b00;
      if (state_q == ST_IDLE) begin
         case (req_valid)
            2'b01:   req_ready = 2'b01;
            2'b10:   req_ready = 2'b10;
            2'b11:   req_ready = last_q ? 2'b01 : 2'b10;
            default: req_ready = 2'b00;
         endcase
      end
      accept  = |(req_valid & req_ready);
      grant_b = req_ready[1];
   end

   // Next-state, operation latch and registered array/response outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      owner_d     = owner_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      last_d      = last_q;
      rsp_rdata_d = rsp_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               owner_d = grant_b;
               we_d    = grant_b ? req_we[1] : req_we[0];
               addr_d  = grant_b ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
               wdata_d = grant_b ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
               last_d  = grant_b;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_d = ST_STROBE;
            cnt_d   = STROBE_LOAD;
         end
         ST_STROBE: begin
            if (cnt_q <= 4'd1) begin
               // Only the edge that ends the final strobe cycle captures read data.
               state_d = ST_RELEASE;
               cnt_d   = 4'd0;
               if (!we_q) begin
                  rsp_rdata_d = mem_q;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RELEASE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Array outputs are derived from the next state so they switch on the
      // same edge as the FSM without any output glitching.
      mem_sel_d = '0;
      if (state_d == ST_STROBE) begin
         mem_sel_d[addr_d] = 1'b1;
      end
      mem_rw_d   = (state_d != ST_IDLE) && we_d;
      mem_data_d = ((state_d != ST_IDLE) && we_d) ? wdata_d : '0;

      rsp_valid_d = 2'b00;
      if (state_d == ST_RELEASE) begin
         rsp_valid_d[owner_d] = 1'b1;
      end
   end

   // State and output registers; reset drops the array interface at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         last_q      <= 1'b1;
         mem_sel_q   <= '0;
         mem_rw_q    <= 1'b0;
         mem_data_q  <= '0;
         rsp_valid_q <= 2'b00;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         last_q      <= last_d;
         mem_sel_q   <= mem_sel_d;
         mem_rw_q    <= mem_rw_d;
         mem_data_q  <= mem_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign mem_sel   = mem_sel_q;
   assign mem_rw    = mem_rw_q;
   assign mem_data  = mem_data_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bit_mem_ctrl.sv
// Bench for bit_mem_ctrl with a three-cycle strobe.
// A latch-array model answers mem_q. A cycle-level reference tracks each
// accepted operation by its accept cycle and predicts arbitration, the
// array waveforms and the response. Responses go through an expected queue.
module tb_bit_mem_ctrl;
   localparam int ADDR_W = 3;
   localparam int DATA_W = 8;
   localparam int S      = 3;
   localparam int ROWS   = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid, req_we, req_ready, rsp_valid;
   logic [5:0]  req_addr;
   logic [15:0] req_wdata;
   logic [7:0]  rsp_rdata, mem_sel, mem_data, mem_q;
   logic        mem_rw, busy;

   always #5 clk = ~clk;

   bit_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STROBE_CYCLES(S)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .mem_sel(mem_sel), .mem_rw(mem_rw), .mem_data(mem_data), .mem_q(mem_q),
      .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- array model ----------------
   logic [7:0] arr [ROWS] = '{default: 8'h00};
   logic       ovr_en = 1'b0;          // forces a per-strobe-cycle pattern on mem_q
   logic [7:0] ovr_k  = 8'h00;

   always_comb begin
      mem_q = 8'h00;
      for (int i = 0; i < ROWS; i++) begin
         if (mem_sel[i]) mem_q = mem_q | arr[i];
      end
      if (ovr_en) mem_q = 8'(8'h11 * (ovr_k + 8'd1));
   end

   always @(posedge clk) begin
      for (int i = 0; i < ROWS; i++) begin
         if (mem_sel[i] && mem_rw) arr[i] <= mem_data;
      end
      ovr_k <= (mem_sel != 8'h00) ? ovr_k + 8'd1 : 8'h00;
   end

   // ---------------- reference model + scoreboard ----------------
   typedef struct packed {
      logic [31:0] due;
      logic [1:0]  own;
      logic        chk;
      logic [7:0]  rdata;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] ref_mem   [ROWS] = '{default: 8'h00};
   bit         ref_known [ROWS] = '{default: 1'b1};
   int         cyc = 0;
   bit         op_act = 1'b0;
   int         op_c = 0;
   bit         op_we = 1'b0;
   int         op_addr = 0;
   logic [7:0] op_wd = 8'h00;
   bit         last_b = 1'b1;
   logic [7:0] last_rd = 8'h00;
   bit         last_known = 1'b1;

   function automatic logic [1:0] pick(input logic [1:0] v, input bit lb);
      return (v == 2'b11) ? (lb ? 2'b01 : 2'b10) : v;
   endfunction

   always @(negedge clk) begin
      logic [1:0] exp_rdy, acc;
      logic [7:0] e_sel, e_data;
      int         off, gb;
      exp_t       e;
      cyc++;
      if (!rst_n) begin
         if (op_act && op_we) ref_known[op_addr] = 1'b0;
         op_act = 1'b0; last_b = 1'b1; last_rd = 8'h00; last_known = 1'b1;
         exp_q.delete();
         check("reset_outputs", {mem_sel, mem_rw, mem_data, rsp_valid, rsp_rdata, busy}, 32'h0);
         check("reset_ready", {30'h0, req_ready}, {30'h0, pick(req_valid, 1'b1)});
      end else begin
         if (op_act && (cyc - op_c) >= S + 3) op_act = 1'b0;
         off    = cyc - op_c;
         e_sel  = (op_act && off >= 2 && off <= S + 1) ? 8'(1 << op_addr) : 8'h00;
         e_data = (op_act && op_we) ? op_wd : 8'h00;
         check("busy", {31'h0, busy}, {31'h0, op_act});
         check("mem_sel", {24'h0, mem_sel}, {24'h0, e_sel});
         check("mem_rw", {31'h0, mem_rw}, {31'h0, (op_act && op_we)});
         check("mem_data", {24'h0, mem_data}, {24'h0, e_data});

         if (rsp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", {30'h0, rsp_valid}, 32'h0);
            end else begin
               e = exp_q.pop_front();
               check("rsp_owner", {30'h0, rsp_valid}, {30'h0, e.own});
               check("rsp_cycle", cyc, e.due);
               if (e.chk) check("rsp_rdata", {24'h0, rsp_rdata}, {24'h0, e.rdata});
            end
         end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
            e = exp_q.pop_front();
            check("rsp_missing", 32'h0, {30'h0, e.own});
         end

         exp_rdy = op_act ? 2'b00 : pick(req_valid, last_b);
         check("req_ready", {30'h0, req_ready}, {30'h0, exp_rdy});
         acc = req_valid & exp_rdy;
         if (acc != 2'b00) begin
            gb      = acc[1] ? 1 : 0;
            op_act  = 1'b1;
            op_c    = cyc;
            op_we   = req_we[gb];
            op_addr = int'(req_addr[gb*3 +: 3]);
            op_wd   = req_wdata[gb*8 +: 8];
            last_b  = acc[1];
            e.due   = 32'(cyc + S + 2);
            e.own   = acc;
            if (op_we) begin
               ref_mem[op_addr]   = op_wd;
               ref_known[op_addr] = 1'b1;
               e.rdata = last_rd;
               e.chk   = last_known;
            end else begin
               e.rdata    = ovr_en ? 8'(8'h11 * S) : ref_mem[op_addr];
               e.chk      = ovr_en ? 1'b1 : ref_known[op_addr];
               last_rd    = e.rdata;
               last_known = e.chk;
            end
            exp_q.push_back(e);
         end
      end
   end

   // ---------------- driver ----------------
   bit         pend_v   [2];
   bit         pend_we  [2];
   logic [2:0] pend_addr[2];
   logic [7:0] pend_wd  [2];
   logic [1:0] last_hs = 2'b00;

   task automatic apply_ports();
      for (int r = 0; r < 2; r++) begin
         req_valid[r]         = pend_v[r];
         req_we[r]            = pend_we[r];
         req_addr[r*3 +: 3]   = pend_addr[r];
         req_wdata[r*8 +: 8]  = pend_wd[r];
      end
   endtask

   task automatic issue(input int r, input bit we, input logic [2:0] addr, input logic [7:0] wd);
      pend_v[r] = 1'b1; pend_we[r] = we; pend_addr[r] = addr; pend_wd[r] = wd;
      apply_ports();
   endtask

   // Each cycle: note the handshake, retire accepted requests, maybe withdraw
   // or spawn random ones. prob is the spawn chance in percent.
   task automatic run_cycles(input int n, input int prob);
      logic [1:0] hs;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         hs = rst_n ? (req_valid & req_ready) : 2'b00;
         last_hs = hs;
         @(posedge clk);
         #1;
         for (int r = 0; r < 2; r++) begin
            if (hs[r]) pend_v[r] = 1'b0;
            else if (pend_v[r] && prob > 0 && prob < 100 && $urandom_range(0, 99) < 3) pend_v[r] = 1'b0;
            if (!pend_v[r] && $urandom_range(0, 99) < prob)
               issue(r, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
         end
         apply_ports();
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int w;
      rst_n = 1'b0;
      for (int r = 0; r < 2; r++) begin
         pend_v[r] = 1'b0; pend_we[r] = 1'b0; pend_addr[r] = 3'd0; pend_wd[r] = 8'h00;
      end
      apply_ports();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      run_cycles(3, 0);
      check("idle_ready", {30'h0, req_ready}, 32'h0);
      check("idle_busy", {31'h0, busy}, 32'h0);

      // A writes 0xA5 to row 5, then B reads it back.
      issue(0, 1'b1, 3'd5, 8'hA5);
      run_cycles(S + 6, 0);
      check("row5_stored", {24'h0, arr[5]}, 32'hA5);
      issue(1, 1'b0, 3'd5, 8'h00);
      run_cycles(S + 6, 0);

      // Both requesters continuously pending: grants must alternate.
      run_cycles(4 * (S + 3), 100);
      run_cycles(3 * (S + 3) + 6, 0);

      // Read sampled only at the end of the last strobe cycle.
      ovr_en = 1'b1;
      issue(1, 1'b0, 3'd2, 8'h00);
      run_cycles(S + 6, 0);
      ovr_en = 1'b0;

      // Reset in the middle of an A write strobe.
      issue(0, 1'b1, 3'd3, 8'h5C);
      w = 0;
      while (mem_sel == 8'h00 && w < 20) begin
         run_cycles(1, 0);
         w++;
      end
      check("strobe_reached", {31'h0, (mem_sel != 8'h00)}, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      check("abort_sel", {24'h0, mem_sel}, 32'h0);
      check("abort_busy", {31'h0, busy}, 32'h0);
      check("abort_rsp", {30'h0, rsp_valid}, 32'h0);
      pend_v[0] = 1'b0;
      issue(0, 1'b1, 3'd6, 8'h3C);
      issue(1, 1'b1, 3'd7, 8'hC3);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_cycles(1, 0);
      check("first_grant_after_reset", {30'h0, last_hs}, 32'h1);
      run_cycles(2 * (S + 3) + 6, 0);

      // Random mixed traffic, then drain.
      run_cycles(400, 35);
      run_cycles(3 * (S + 3) + 8, 0);

      check("queue_empty", exp_q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
